// File: rtl/b_vpe_tm.sv
// Time-multiplexed variable processing element: accumulates a signed literal vote and
// a clause-satisfaction flag over NSLICE beats, then greedily updates the variable bit.
module b_vpe_tm #(
  parameter int NCLAUSE = 32,
  parameter int NSLICE  = 4,
  parameter int SUM_W   = $clog2(NCLAUSE*NSLICE+1)+1
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    START,
  input  logic                    EVAL_ONLY,
  input  logic                    VAR_STATE,
  input  logic                    V_PRE,
  input  logic                    SLICE_VALID,
  output logic                    SLICE_READY,
  input  logic [NCLAUSE-1:0]      C0,
  input  logic [NCLAUSE-1:0]      C1,
  input  logic                    SATISFY_UP,
  input  logic                    SATISFY_LEFT,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    FLIP,
  output logic                    VI_BUS,
  output logic signed [SUM_W-1:0] SUM,
  output logic                    SATISFY
);

  localparam int CNT_W = $clog2(NSLICE+1);

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, FINISH} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        slice_cnt;
  logic                    sat_acc;
  logic                    eval_only_q;
  logic                    flip_q;
  logic                    vi;
  logic signed [SUM_W-1:0] sum_q;
  logic signed [SUM_W-1:0] slice_vote;
  logic                    slice_sat;
  logic                    beat;
  logic                    last_beat;
  logic                    vi_next;

  assign beat      = (state == ACCUM) && SLICE_VALID;
  assign last_beat = (slice_cnt == CNT_W'(NSLICE-1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START) state_next = ACCUM;
      ACCUM:   if (beat && last_beat) state_next = UPDATE;
      UPDATE:  state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Each present clause votes toward satisfying its own literal.
  always_comb begin
    slice_vote = '0;
    for (int i = 0; i < NCLAUSE; i++) begin
      if (C0[i]) begin
        if (C1[i]) slice_vote = slice_vote - SUM_W'(1);
        else       slice_vote = slice_vote + SUM_W'(1);
      end
    end
  end

  assign slice_sat = &(~C0 | (C1 ^ {NCLAUSE{vi}}));

  always_comb begin
    vi_next = vi;
    if (!eval_only_q) begin
      if (sum_q[SUM_W-1])    vi_next = 1'b0;
      else if (sum_q != '0)  vi_next = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vi          <= 1'b0;
      sum_q       <= '0;
      sat_acc     <= 1'b0;
      slice_cnt   <= '0;
      eval_only_q <= 1'b0;
      flip_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (VAR_STATE) vi <= V_PRE;
          if (START) begin
            sum_q       <= '0;
            sat_acc     <= 1'b1;
            slice_cnt   <= '0;
            eval_only_q <= EVAL_ONLY;
          end
        end
        ACCUM: begin
          if (SLICE_VALID) begin
            sum_q     <= sum_q + slice_vote;
            sat_acc   <= sat_acc & slice_sat;
            slice_cnt <= slice_cnt + CNT_W'(1);
          end
        end
        UPDATE: begin
          vi     <= vi_next;
          flip_q <= vi_next ^ vi;
        end
        FINISH:  flip_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign SLICE_READY = (state == ACCUM);
  assign BUSY        = (state != IDLE);
  assign DONE        = (state == FINISH);
  assign FLIP        = (state == FINISH) && flip_q;
  assign VI_BUS      = vi;
  assign SUM         = sum_q;
  assign SATISFY     = sat_acc & SATISFY_UP & SATISFY_LEFT;

endmodule

// File: tb/tb_b_vpe_tm.sv
// Bench for b_vpe_tm: a transaction-level model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic including stray resets.
module tb_b_vpe_tm;

  localparam int NC = 4;
  localparam int NS = 2;
  localparam int SW = $clog2(NC*NS+1)+1;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          START = 1'b0;
  logic          EVAL_ONLY = 1'b0;
  logic          VAR_STATE = 1'b0;
  logic          V_PRE = 1'b0;
  logic          SLICE_VALID = 1'b0;
  logic          SATISFY_UP = 1'b1;
  logic          SATISFY_LEFT = 1'b1;
  logic [NC-1:0] C0 = '0;
  logic [NC-1:0] C1 = '0;
  logic          SLICE_READY, BUSY, DONE, FLIP, VI_BUS, SATISFY;
  logic signed [SW-1:0] SUM;

  int vectors = 0;
  int miscompares = 0;

  // Model: busy flag, beats taken, post-accumulation countdown (2 = update, 1 = done).
  bit mBusy = 0, mVi = 0, mSat = 0, mEo = 0, mFlip = 0;
  int mSum = 0, mBeats = 0, mPost = 0;

  b_vpe_tm #(.NCLAUSE(NC), .NSLICE(NS)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .EVAL_ONLY(EVAL_ONLY),
    .VAR_STATE(VAR_STATE), .V_PRE(V_PRE), .SLICE_VALID(SLICE_VALID),
    .SLICE_READY(SLICE_READY), .C0(C0), .C1(C1), .SATISFY_UP(SATISFY_UP),
    .SATISFY_LEFT(SATISFY_LEFT), .BUSY(BUSY), .DONE(DONE), .FLIP(FLIP),
    .VI_BUS(VI_BUS), .SUM(SUM), .SATISFY(SATISFY)
  );

  always #5 CLK = ~CLK;

  function automatic int voteOf(input logic [NC-1:0] c0, input logic [NC-1:0] c1);
    int v = 0;
    for (int i = 0; i < NC; i++) if (c0[i]) v += (c1[i] ? -1 : 1);
    return v;
  endfunction

  function automatic bit satOf(input logic [NC-1:0] c0, input logic [NC-1:0] c1, input bit v);
    bit s = 1;
    for (int i = 0; i < NC; i++) if (c0[i] && (c1[i] == v)) s = 0;
    return s;
  endfunction

  function automatic bit greedy(input bit eo, input int s, input bit v);
    if (eo)    return v;
    if (s > 0) return 1'b1;
    if (s < 0) return 1'b0;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mBusy <= 0; mVi <= 0; mSat <= 0; mEo <= 0; mFlip <= 0;
      mSum <= 0; mBeats <= 0; mPost <= 0;
    end else if (!mBusy) begin
      if (VAR_STATE) mVi <= V_PRE;
      if (START) begin
        mBusy <= 1; mSum <= 0; mSat <= 1; mBeats <= 0; mPost <= 0; mEo <= EVAL_ONLY;
      end
    end else if (mPost == 0) begin
      if (SLICE_VALID) begin
        mSum   <= mSum + voteOf(C0, C1);
        mSat   <= mSat && satOf(C0, C1, mVi);
        mBeats <= mBeats + 1;
        if (mBeats == NS-1) mPost <= 2;
      end
    end else if (mPost == 2) begin
      mVi   <= greedy(mEo, mSum, mVi);
      mFlip <= (greedy(mEo, mSum, mVi) != mVi);
      mPost <= 1;
    end else begin
      mBusy <= 0; mPost <= 0; mFlip <= 0;
    end
  end

  always @(negedge CLK) begin
    checkOutput("busy",    BUSY,        mBusy);
    checkOutput("ready",   SLICE_READY, mBusy && mPost == 0);
    checkOutput("done",    DONE,        mPost == 1);
    checkOutput("flip",    FLIP,        (mPost == 1) && mFlip);
    checkOutput("vi",      VI_BUS,      mVi);
    checkOutput("sum",     $signed(SUM), mSum);
    checkOutput("satisfy", SATISFY,     mSat && SATISFY_UP && SATISFY_LEFT);
  end

  // One evaluation: START (optionally with preset), beat A, optional stalls with a
  // stray START, beat B, then wait for DONE. lat counts edges after the START edge.
  task automatic applyStimulus(input logic [NC-1:0] c0a, input logic [NC-1:0] c1a,
                               input logic [NC-1:0] c0b, input logic [NC-1:0] c1b,
                               input bit eo, input bit pre, input bit pv,
                               input int stalls, output int lat);
    bit seen;
    VAR_STATE = pre; V_PRE = pv; EVAL_ONLY = eo; START = 1;
    tick();
    VAR_STATE = 0; START = 0; EVAL_ONLY = 0;
    lat = 0;
    SLICE_VALID = 1; C0 = c0a; C1 = c1a;
    tick(); lat++;
    repeat (stalls) begin
      SLICE_VALID = 0; START = 1; C0 = NC'($urandom); C1 = NC'($urandom);
      tick(); lat++;
    end
    START = 0; SLICE_VALID = 1; C0 = c0b; C1 = c1b;
    tick(); lat++;
    SLICE_VALID = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (DONE) seen = 1;
      else begin tick(); lat++; end
    end
    if (!seen) checkOutput("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    #2;
    checkOutput("rst_busy",  BUSY, 0);
    checkOutput("rst_ready", SLICE_READY, 0);
    checkOutput("rst_done",  DONE, 0);
    checkOutput("rst_vi",    VI_BUS, 0);
    checkOutput("rst_sum",   $signed(SUM), 0);
    checkOutput("rst_sat",   SATISFY, 0);
    tick();
    RESET_N = 1;
    tick();

    // +4 vote from VI=0: flips to 1; positive literals were unsatisfied at VI=0.
    applyStimulus(4'b1111, 4'b0000, 4'b0011, 4'b0001, 0, 0, 0, 0, lat);
    checkOutput("t1_sum", $signed(SUM), 4);
    checkOutput("t1_vi", VI_BUS, 1);
    checkOutput("t1_flip", FLIP, 1);
    checkOutput("t1_sat", SATISFY, 0);
    checkOutput("t1_lat", lat, NS+1);
    tick();

    VAR_STATE = 1; V_PRE = 0;
    tick();
    VAR_STATE = 0;
    checkOutput("preset0_vi", VI_BUS, 0);

    // Preset to 1 together with START, net -1 vote flips back to 0.
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, 1, 1, 0, lat);
    checkOutput("t2_sum", $signed(SUM), -1);
    checkOutput("t2_vi", VI_BUS, 0);
    checkOutput("t2_flip", FLIP, 1);
    checkOutput("t2_lat", lat, NS+1);
    tick();

    applyStimulus(4'b0111, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, lat);
    checkOutput("t3_vi", VI_BUS, 0);
    checkOutput("t3_flip", FLIP, 0);
    checkOutput("t3_sum", $signed(SUM), 3);
    repeat (3) tick();
    checkOutput("t3_sum_held", $signed(SUM), 3);
    checkOutput("t3_idle", BUSY, 0);

    applyStimulus(4'b0011, 4'b0001, 4'b0000, 4'b0000, 0, 1, 1, 0, lat);
    checkOutput("t4_sum", $signed(SUM), 0);
    checkOutput("t4_vi", VI_BUS, 1);
    checkOutput("t4_flip", FLIP, 0);
    tick();

    applyStimulus(4'b1000, 4'b1000, 4'b0100, 4'b0100, 0, 0, 0, 2, lat);
    checkOutput("t5_lat", lat, NS+3);
    checkOutput("t5_sum", $signed(SUM), -2);
    checkOutput("t5_vi", VI_BUS, 0);
    checkOutput("t5_flip", FLIP, 1);
    tick();
    checkOutput("t5_idle", BUSY, 0);

    // Abort in ACCUM after the first beat.
    VAR_STATE = 1; V_PRE = 1; START = 1;
    tick();
    VAR_STATE = 0; START = 0; SLICE_VALID = 1; C0 = 4'b1111; C1 = 4'b0000;
    tick();
    SLICE_VALID = 0;
    checkOutput("t6_pre_busy", BUSY, 1);
    RESET_N = 0;
    #1;
    checkOutput("t6_busy", BUSY, 0);
    checkOutput("t6_sum", $signed(SUM), 0);
    checkOutput("t6_vi", VI_BUS, 0);
    checkOutput("t6_ready", SLICE_READY, 0);
    tick();
    RESET_N = 1;
    tick();

    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, lat);
    checkOutput("t7_lat", lat, NS+1);
    checkOutput("t7_sat", SATISFY, 1);
    SATISFY_LEFT = 0;
    #1;
    checkOutput("t7_left0", SATISFY, 0);
    SATISFY_LEFT = 1;
    tick();

    for (int n = 0; n < 600; n++) begin
      START        = ($urandom_range(0, 3) == 0);
      VAR_STATE    = ($urandom_range(0, 3) == 0);
      V_PRE        = 1'($urandom);
      EVAL_ONLY    = ($urandom_range(0, 3) == 0);
      SLICE_VALID  = ($urandom_range(0, 3) != 0);
      C0           = NC'($urandom);
      C1           = NC'($urandom);
      SATISFY_UP   = ($urandom_range(0, 7) != 0);
      SATISFY_LEFT = ($urandom_range(0, 7) != 0);
      RESET_N      = ($urandom_range(0, 149) != 0);
      tick();
    end
    RESET_N = 1; START = 0; SLICE_VALID = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
